axi2per_res_channel: RTL and testbench
======================================

Name: axi2per_res_channel

Overview:
Response stage of the AXI-to-peripheral bridge, directly downstream of the request channel.
- Takes the pending-transaction descriptor (trans_*) issued when the peripheral grants a request.
- Waits for the peripheral response and returns it as a single-beat AXI R or B response.
- Pulses trans_r_valid_o on AXI handshake completion so the request channel returns to idle and accepts the next transaction.

Parameters:
PER_ID_WIDTH, 5, peripheral response ID width (ID value not checked)
AXI_ADDR_WIDTH, 32, transaction address width
AXI_DATA_WIDTH, 64, AXI data width; only 64 supported (elaboration error otherwise)
AXI_USER_WIDTH, 6, AXI user width
AXI_ID_WIDTH, 3, AXI ID width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
per_slave_r_valid_i  in  1  peripheral response valid (one-cycle pulse)
per_slave_r_opc_i  in  1  peripheral error flag; 1 = error
per_slave_r_id_i  in  PER_ID_WIDTH  peripheral response ID (unused)
per_slave_r_rdata_i  in  32  peripheral read data
trans_req_i  in  1  new pending transaction, one-cycle pulse
trans_we_i  in  1  transaction type: 1 = read, 0 = write (request-channel encoding)
trans_id_i  in  AXI_ID_WIDTH  AXI ID of transaction
trans_add_i  in  AXI_ADDR_WIDTH  transaction address
trans_r_valid_o  out  1  transaction completed pulse
axi_slave_r_valid_o  out  1  AXI R valid
axi_slave_r_data_o  out  AXI_DATA_WIDTH  AXI R data
axi_slave_r_resp_o  out  2  AXI R response
axi_slave_r_last_o  out  1  AXI R last
axi_slave_r_id_o  out  AXI_ID_WIDTH  AXI R ID
axi_slave_r_user_o  out  AXI_USER_WIDTH  AXI R user
axi_slave_r_ready_i  in  1  AXI R ready
axi_slave_b_valid_o  out  1  AXI B valid
axi_slave_b_resp_o  out  2  AXI B response
axi_slave_b_id_o  out  AXI_ID_WIDTH  AXI B ID
axi_slave_b_user_o  out  AXI_USER_WIDTH  AXI B user
axi_slave_b_ready_i  in  1  AXI B ready

Behaviour:
- Reset (rst_i high, async): state IDLE; every output 0; all capture registers 0.
- FSM states: IDLE, WAIT_PER, RESP_R, RESP_B.
- IDLE:
  - trans_req_i=1 -> latch trans_we_i, trans_id_i, trans_add_i[2]; go to WAIT_PER.
  - per_slave_r_valid_i in IDLE is ignored (no output change).
- WAIT_PER: on per_slave_r_valid_i=1, capture rdata and opc, then:
  - trans_we=1 -> RESP_R
  - trans_we=0 -> RESP_B
  - If per_slave_r_valid_i does not arrive, the block stays in WAIT_PER.
- Data placement (R): add[2]=0 -> r_data = {32'h0, rdata}; add[2]=1 -> r_data = {rdata, 32'h0}.
- Response code: opc=1 -> SLVERR (2'b10); opc=0 -> OKAY (2'b00). Write data returned by the peripheral is discarded.
- RESP_R:
  - r_valid=1, r_last=1, r_id = latched ID, r_user=0; data/resp/id held stable while r_ready=0.
  - On r_valid & r_ready: trans_r_valid_o=1 in that same cycle (combinational); next state IDLE, r_valid=0.
- RESP_B: same as RESP_R using the b_* ports.
- Latency: per_slave_r_valid_i at cycle N -> AXI valid at N+1 (registered outputs). With ready already high, trans_r_valid_o also pulses at N+1.
- trans_r_valid_o is high for exactly one cycle per transaction; never asserted outside RESP_R/RESP_B.
- r_valid and b_valid are never high together; at most one outstanding transaction.
- trans_req_i outside IDLE is ignored (protocol violation; upstream guarantees it does not occur).
- Reset mid-transaction: state returns to IDLE and valids drop immediately. The pending transaction is lost, with no trans_r_valid_o pulse.
- Single beat only: AXI len/burst are not handled; r_last is always 1 with r_valid.

Test Plan:
- Read, ready high: trans_req (we=1, id=3, add=0x1000_0004); r_valid 2 cycles later with rdata=0xDEADBEEF, opc=0 -> next cycle r_valid=1, r_data=0xDEADBEEF_00000000, r_resp=00, r_id=3, r_last=1, trans_r_valid_o pulses once.
- Write, backpressure: trans_req (we=0, id=5, add=0x0); per response opc=0; b_ready low 3 cycles -> b_valid held with b_resp=00, b_id=5, no trans_r_valid_o; b_ready high -> single pulse, back to IDLE.
- Error: read at add=0x0 with opc=1, rdata=0x12345678 -> r_resp=10, r_data=0x00000000_12345678.
- Spurious per_slave_r_valid_i in IDLE -> no r_valid/b_valid/trans_r_valid_o; a following normal read completes correctly.
- Reset asserted in WAIT_PER, then per response arrives after release -> no AXI response; all outputs stay 0.
- Back-to-back: read then write with r_ready/b_ready tied high -> exactly two trans_r_valid_o pulses, correct IDs, no overlap of r_valid and b_valid.

Source files
------------

// File: rtl/axi2per_res_channel.sv
// Response stage of the AXI-to-peripheral bridge. It holds one pending transaction
// descriptor and returns the peripheral reply as a single-beat AXI R or B response.
module axi2per_res_channel #(
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_WIDTH   = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      per_slave_r_valid_i,
  input  logic                      per_slave_r_opc_i,
  input  logic [PER_ID_WIDTH-1:0]   per_slave_r_id_i,
  input  logic [31:0]               per_slave_r_rdata_i,
  input  logic                      trans_req_i,
  input  logic                      trans_we_i,
  input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i,
  output logic                      trans_r_valid_o,
  output logic                      axi_slave_r_valid_o,
  output logic [AXI_DATA_WIDTH-1:0] axi_slave_r_data_o,
  output logic [1:0]                axi_slave_r_resp_o,
  output logic                      axi_slave_r_last_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_r_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_r_user_o,
  input  logic                      axi_slave_r_ready_i,
  output logic                      axi_slave_b_valid_o,
  output logic [1:0]                axi_slave_b_resp_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_slave_b_id_o,
  output logic [AXI_USER_WIDTH-1:0] axi_slave_b_user_o,
  input  logic                      axi_slave_b_ready_i
);

  generate
    if (AXI_DATA_WIDTH != 64) begin : g_bad_data_width
      $error("axi2per_res_channel supports only AXI_DATA_WIDTH = 64");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT_PER, RESP_R, RESP_B} state_t;

  state_t                  state_reg;
  logic                    we_reg;
  logic                    add2_reg;
  logic [AXI_ID_WIDTH-1:0] id_reg;
  logic [1:0]              resp_next;

  // The peripheral ID is not checked and only address bit 2 selects the data lane.
  logic unused_inputs;
  assign unused_inputs = ^{per_slave_r_id_i, trans_add_i};

  assign resp_next = per_slave_r_opc_i ? 2'b10 : 2'b00;

  assign axi_slave_r_user_o = '0;
  assign axi_slave_b_user_o = '0;

  // Completion is reported in the same cycle as the AXI handshake.
  assign trans_r_valid_o = ((state_reg == RESP_R) && axi_slave_r_ready_i) ||
                           ((state_reg == RESP_B) && axi_slave_b_ready_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg           <= IDLE;
      we_reg              <= 1'b0;
      add2_reg            <= 1'b0;
      id_reg              <= '0;
      axi_slave_r_valid_o <= 1'b0;
      axi_slave_r_data_o  <= '0;
      axi_slave_r_resp_o  <= 2'b00;
      axi_slave_r_last_o  <= 1'b0;
      axi_slave_r_id_o    <= '0;
      axi_slave_b_valid_o <= 1'b0;
      axi_slave_b_resp_o  <= 2'b00;
      axi_slave_b_id_o    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (trans_req_i) begin
            we_reg    <= trans_we_i;
            id_reg    <= trans_id_i;
            add2_reg  <= trans_add_i[2];
            state_reg <= WAIT_PER;
          end
        end
        WAIT_PER: begin
          if (per_slave_r_valid_i) begin
            if (we_reg) begin
              axi_slave_r_valid_o <= 1'b1;
              axi_slave_r_last_o  <= 1'b1;
              axi_slave_r_resp_o  <= resp_next;
              axi_slave_r_id_o    <= id_reg;
              axi_slave_r_data_o  <= add2_reg ? {per_slave_r_rdata_i, 32'h0}
                                              : {32'h0, per_slave_r_rdata_i};
              state_reg           <= RESP_R;
            end else begin
              axi_slave_b_valid_o <= 1'b1;
              axi_slave_b_resp_o  <= resp_next;
              axi_slave_b_id_o    <= id_reg;
              state_reg           <= RESP_B;
            end
          end
        end
        RESP_R: begin
          if (axi_slave_r_ready_i) begin
            axi_slave_r_valid_o <= 1'b0;
            axi_slave_r_last_o  <= 1'b0;
            state_reg           <= IDLE;
          end
        end
        RESP_B: begin
          if (axi_slave_b_ready_i) begin
            axi_slave_b_valid_o <= 1'b0;
            state_reg           <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi2per_res_channel.sv
// Scoreboard bench for axi2per_res_channel: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever an AXI R/B response is presented.
module tb_axi2per_res_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic        per_valid, per_opc;
  logic [4:0]  per_id;
  logic [31:0] per_rdata;
  logic        trans_req, trans_we;
  logic [2:0]  trans_id;
  logic [31:0] trans_add;
  logic        trans_r_valid;
  logic        r_valid, r_last, r_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp, b_resp;
  logic [2:0]  r_id, b_id;
  logic [5:0]  r_user, b_user;
  logic        b_valid, b_ready;

  axi2per_res_channel dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .per_slave_r_valid_i (per_valid),
    .per_slave_r_opc_i   (per_opc),
    .per_slave_r_id_i    (per_id),
    .per_slave_r_rdata_i (per_rdata),
    .trans_req_i         (trans_req),
    .trans_we_i          (trans_we),
    .trans_id_i          (trans_id),
    .trans_add_i         (trans_add),
    .trans_r_valid_o     (trans_r_valid),
    .axi_slave_r_valid_o (r_valid),
    .axi_slave_r_data_o  (r_data),
    .axi_slave_r_resp_o  (r_resp),
    .axi_slave_r_last_o  (r_last),
    .axi_slave_r_id_o    (r_id),
    .axi_slave_r_user_o  (r_user),
    .axi_slave_r_ready_i (r_ready),
    .axi_slave_b_valid_o (b_valid),
    .axi_slave_b_resp_o  (b_resp),
    .axi_slave_b_id_o    (b_id),
    .axi_slave_b_user_o  (b_user),
    .axi_slave_b_ready_i (b_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_read;
    logic [63:0] data;
    logic [1:0]  resp;
    logic [2:0]  id;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   hs_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic push(input logic is_read, input logic [63:0] data,
                      input logic [1:0] resp, input logic [2:0] id);
    exp_t e;
    e.is_read = is_read; e.data = data; e.resp = resp; e.id = id;
    q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic we, input logic [2:0] id, input logic [31:0] add);
    trans_req = 1'b1; trans_we = we; trans_id = id; trans_add = add;
    cyc(1);
    trans_req = 1'b0; trans_we = 1'b0; trans_id = '0; trans_add = '0;
  endtask

  task automatic per_resp(input logic [31:0] rdata, input logic opc);
    per_valid = 1'b1; per_rdata = rdata; per_opc = opc; per_id = 5'h11;
    cyc(1);
    per_valid = 1'b0; per_rdata = '0; per_opc = 1'b0; per_id = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      cyc(1);
      n++;
    end
    if (q.size() != 0) begin
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      n_checks++;
      q.delete();
    end
  endtask

  // Monitor: compares any presented response against the front of the queue.
  always @(negedge clk) begin
    if (!rst && (r_valid || b_valid || trans_r_valid)) begin
      logic hs;
      exp_t e;
      hs = (r_valid && r_ready) || (b_valid && b_ready);
      chk("trans_r_valid", {63'b0, trans_r_valid}, {63'b0, hs});
      chk("valid_overlap", {63'b0, r_valid && b_valid}, 64'd0);
      if (q.size() == 0) begin
        fail("unexpected_resp");
      end else begin
        e = q[0];
        chk("resp_kind", {63'b0, r_valid}, {63'b0, e.is_read});
        if (e.is_read) begin
          chk("r_data", r_data, e.data);
          chk("r_resp", {62'b0, r_resp}, {62'b0, e.resp});
          chk("r_id",   {61'b0, r_id},   {61'b0, e.id});
          chk("r_last", {63'b0, r_last}, 64'd1);
          chk("r_user", {58'b0, r_user}, 64'd0);
        end else begin
          chk("b_resp", {62'b0, b_resp}, {62'b0, e.resp});
          chk("b_id",   {61'b0, b_id},   {61'b0, e.id});
          chk("b_user", {58'b0, b_user}, 64'd0);
        end
        if (hs) begin
          void'(q.pop_front());
          hs_count++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_before;
    rst = 1'b1;
    per_valid = 0; per_opc = 0; per_id = '0; per_rdata = '0;
    trans_req = 0; trans_we = 0; trans_id = '0; trans_add = '0;
    r_ready = 1'b1; b_ready = 1'b1;
    cyc(2);
    chk("rst_r_valid", {63'b0, r_valid}, 64'd0);
    chk("rst_b_valid", {63'b0, b_valid}, 64'd0);
    chk("rst_trans_r_valid", {63'b0, trans_r_valid}, 64'd0);
    chk("rst_r_data", r_data, 64'd0);
    chk("rst_r_fields", {52'b0, r_resp, r_last, r_id, r_user}, 64'd0);
    chk("rst_b_fields", {53'b0, b_resp, b_id, b_user}, 64'd0);
    rst = 1'b0;
    cyc(2);

    // Read, ready high, upper lane
    start(1'b1, 3'd3, 32'h1000_0004);
    cyc(1);
    push(1'b1, 64'hDEADBEEF_00000000, 2'b00, 3'd3);
    per_resp(32'hDEADBEEF, 1'b0);
    chk("latency_r_valid", {63'b0, r_valid}, 64'd1);
    wait_drain();

    // Write with 3 cycles of backpressure
    b_ready = 1'b0;
    start(1'b0, 3'd5, 32'h0);
    push(1'b0, 64'd0, 2'b00, 3'd5);
    per_resp(32'hAAAA_5555, 1'b0);
    chk("latency_b_valid", {63'b0, b_valid}, 64'd1);
    cyc(3);
    chk("b_valid_held", {63'b0, b_valid}, 64'd1);
    b_ready = 1'b1;
    wait_drain();
    chk("b_valid_after_hs", {63'b0, b_valid}, 64'd0);

    // Error read, lower lane
    start(1'b1, 3'd1, 32'h0);
    push(1'b1, 64'h00000000_12345678, 2'b10, 3'd1);
    per_resp(32'h1234_5678, 1'b1);
    wait_drain();

    // Spurious peripheral response in IDLE, then a normal read
    per_resp(32'h5555_5555, 1'b1);
    cyc(3);
    start(1'b1, 3'd7, 32'h4);
    push(1'b1, 64'hCAFEF00D_00000000, 2'b00, 3'd7);
    per_resp(32'hCAFE_F00D, 1'b0);
    wait_drain();

    // Reset while waiting for the peripheral
    start(1'b1, 3'd2, 32'h4);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk("midrst_valids", {62'b0, r_valid, b_valid}, 64'd0);
    chk("midrst_trans", {63'b0, trans_r_valid}, 64'd0);
    rst = 1'b0;
    cyc(1);
    per_resp(32'h7777_7777, 1'b0);
    cyc(3);
    chk("postrst_valids", {62'b0, r_valid, b_valid}, 64'd0);
    start(1'b0, 3'd6, 32'h0);
    push(1'b0, 64'd0, 2'b10, 3'd6);
    per_resp(32'h0, 1'b1);
    wait_drain();

    // Back-to-back read then write, ready tied high
    hs_before = hs_count;
    start(1'b1, 3'd4, 32'h4);
    push(1'b1, 64'h11111111_00000000, 2'b00, 3'd4);
    per_resp(32'h1111_1111, 1'b0);
    cyc(1);
    start(1'b0, 3'd2, 32'h8);
    push(1'b0, 64'd0, 2'b00, 3'd2);
    per_resp(32'h2222_2222, 1'b0);
    wait_drain();
    cyc(2);
    chk("b2b_pulses", 64'(hs_count - hs_before), 64'd2);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
